mem_stage: RTL

- Memory-access pipeline stage. Consumes the EX/MEM register outputs: ALU result, store data, destination register and forwarded control bits.
- Performs byte, halfword and word loads and stores against an internal data memory. Registers the MEM/WB values.
- Drives the MEM-stage forwarding and hazard signals back toward EX and the hazard unit.
- Provides a debug read port used while the core is halted.

---
 rtl/mem_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
//
// Takes the EX/MEM register outputs, performs byte / halfword / word loads
// and stores against an internal word-organised data memory, and registers
// the MEM/WB values. Also returns forwarding/hazard copies of the incoming
// EX/MEM values and a combinational debug read port.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   : misaligned halfword/word accesses are detected; stores are
//               dropped, loads return 0, MEM_C_Misalign_O flags the access.
//   undefined : halfword accesses ignore addr[0], word accesses ignore
//               addr[1:0]; MEM_C_Misalign_O stays 0.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   MEM_ALUOut               byte address / ALU result
//   MEM_DataToWrite          store data
//   MEM_RegToWrite           destination register
//   MEM_PCPlus4              PC+4 for JAL writeback
//   MEM_C_RegWrite           register write enable
//   MEM_C_DataSource         1 = load instruction
//   MEM_C_MemWrite           store enable
//   MEM_C_Jump               jump type (pass-through)
//   MEM_C_StoreLoad          1 = zero-extend loads, 0 = sign-extend
//   MEM_C_Extend             00 byte, 01 halfword, 1x word
//   MEM_C_Halt               halt instruction marker
//   MEM_C_Stall_DB           debug stall, freezes all state
//   MEM_DebugAddr            debug word index
//   MEM_DebugData            combinational word at MEM_DebugAddr
//   MEM_ReadData             registered extended load data
//   MEM_*_O                  registered MEM/WB values
//   MEM_ALUOut_FW, MEM_RegDest_HZ, MEM_C_WriteReg_HZ
//                            combinational forwarding / hazard copies
//   MEM_Halted               sticky halt flag (the only piece of control state)
//   MEM_C_Misalign_O         registered misalignment flag
//
// Handshake: there is no valid/ready flow control. Every edge with
// MEM_C_Stall_DB=0 consumes one instruction from the EX/MEM inputs; with
// MEM_C_Stall_DB=1 the stage neither consumes nor produces.
module mem_stage #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       MEM_ALUOut,
  input  logic [31:0]       MEM_DataToWrite,
  input  logic [4:0]        MEM_RegToWrite,
  input  logic [31:0]       MEM_PCPlus4,
  input  logic              MEM_C_RegWrite,
  input  logic              MEM_C_DataSource,
  input  logic              MEM_C_MemWrite,
  input  logic [1:0]        MEM_C_Jump,
  input  logic              MEM_C_StoreLoad,
  input  logic [1:0]        MEM_C_Extend,
  input  logic              MEM_C_Halt,
  input  logic              MEM_C_Stall_DB,
  input  logic [ADDR_W-1:0] MEM_DebugAddr,
  output logic [31:0]       MEM_DebugData,
  output logic [31:0]       MEM_ReadData,
  output logic [31:0]       MEM_ALUOut_O,
  output logic [31:0]       MEM_PCPlus4_O,
  output logic [4:0]        MEM_RegToWrite_O,
  output logic              MEM_C_RegWrite_O,
  output logic              MEM_C_DataSource_O,
  output logic              MEM_C_Halt_O,
  output logic [1:0]        MEM_C_Jump_O,
  output logic [31:0]       MEM_ALUOut_FW,
  output logic [4:0]        MEM_RegDest_HZ,
  output logic              MEM_C_WriteReg_HZ,
  output logic              MEM_Halted,
  output logic              MEM_C_Misalign_O
);

  // Word-organised storage; contents are deliberately not reset.
  logic [31:0] mem [DEPTH];

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        lane;
  logic [31:0]       cur_word;
  logic [31:0]       shifted;
  logic [15:0]       half_v;
  logic              sext;
  logic              misaligned;
  logic              do_store;
  logic [3:0]        byte_en;
  logic [31:0]       wdata;
  logic [31:0]       load_raw;
  logic [31:0]       load_data;
  logic              halted_q;

  // Upper address bits are dropped, so addresses wrap modulo DEPTH*4.
  assign word_idx = MEM_ALUOut[ADDR_W+1:2];
  assign lane     = MEM_ALUOut[1:0];
  assign cur_word = mem[word_idx];
  assign shifted  = cur_word >> {lane, 3'b000};
  assign half_v   = lane[1] ? cur_word[31:16] : cur_word[15:0];
  assign sext     = ~MEM_C_StoreLoad;

  // Debug read sees the pre-write word when a store hits the same index.
  assign MEM_DebugData = mem[MEM_DebugAddr];

  // Forwarding / hazard copies follow the inputs even during a stall.
  assign MEM_ALUOut_FW     = MEM_ALUOut;
  assign MEM_RegDest_HZ    = MEM_RegToWrite;
  assign MEM_C_WriteReg_HZ = MEM_C_RegWrite;
  assign MEM_Halted        = halted_q;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((MEM_C_Extend == 2'b01) && lane[0]) ||
                      (MEM_C_Extend[1] && (lane != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Store lane enables and replicated write data; load lane extraction.
  always_comb begin
    byte_en  = 4'b0000;
    wdata    = 32'h0;
    load_raw = 32'h0;
    case (MEM_C_Extend)
      2'b00: begin
        byte_en  = 4'b0001 << lane;
        wdata    = {4{MEM_DataToWrite[7:0]}};
        load_raw = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        byte_en  = lane[1] ? 4'b1100 : 4'b0011;
        wdata    = {2{MEM_DataToWrite[15:0]}};
        load_raw = {{16{sext & half_v[15]}}, half_v};
      end
      default: begin
        byte_en  = 4'b1111;
        wdata    = MEM_DataToWrite;
        load_raw = cur_word;
      end
    endcase
  end

  assign load_data = (misaligned && MEM_C_DataSource) ? 32'h0 : load_raw;
  assign do_store  = MEM_C_MemWrite && !MEM_C_Stall_DB && !halted_q && !misaligned;

  always_ff @(posedge clk) begin
    if (do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // MEM/WB register. RegWrite is masked by the halt flag as it will be after
  // this edge, so MEM_C_RegWrite_O is never 1 while MEM_Halted is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MEM_ReadData       <= 32'h0;
      MEM_ALUOut_O       <= 32'h0;
      MEM_PCPlus4_O      <= 32'h0;
      MEM_RegToWrite_O   <= 5'h0;
      MEM_C_RegWrite_O   <= 1'b0;
      MEM_C_DataSource_O <= 1'b0;
      MEM_C_Halt_O       <= 1'b0;
      MEM_C_Jump_O       <= 2'b00;
      MEM_C_Misalign_O   <= 1'b0;
      halted_q           <= 1'b0;
    end else if (!MEM_C_Stall_DB) begin
      MEM_ReadData       <= load_data;
      MEM_ALUOut_O       <= MEM_ALUOut;
      MEM_PCPlus4_O      <= MEM_PCPlus4;
      MEM_RegToWrite_O   <= MEM_RegToWrite;
      MEM_C_RegWrite_O   <= MEM_C_RegWrite && !(halted_q || MEM_C_Halt);
      MEM_C_DataSource_O <= MEM_C_DataSource;
      MEM_C_Halt_O       <= MEM_C_Halt;
      MEM_C_Jump_O       <= MEM_C_Jump;
      MEM_C_Misalign_O   <= misaligned && (MEM_C_MemWrite || MEM_C_DataSource);
      halted_q           <= halted_q || MEM_C_Halt;
    end
  end

endmodule
